poly1305_block_feeder: RTL and testbench
========================================

// Module: poly1305_block_feeder
// PURPOSE
//  Upstream producer for the ChaCha20-Poly1305 tag adapter. Takes the AAD, then payload, as byte streams.
//  Each message is zero-padded to whole 16-byte blocks (RFC 8439), and AAD and payload byte counts are
//  accumulated. Drives the adapter's aad_*, pld_* and len_* valid/ready channels, finishing with the
//  {le64(pld_len), le64(aad_len)} length block. Sits between the DMA/PIM read path and the tag adapter.
// PARAMETERS
//  CNT_W  64  byte-counter width; len_block fields are zero-extended to 64 bits.
// PORTS
//  clk        in   1    clock
//  rst_n      in   1    reset, asynchronous, active-low
//  start      in   1    begin new message; sampled only in IDLE
//  s_valid    in   1    upstream beat valid
//  s_data     in   128  beat data; byte lane 0 = s_data[7:0] = first byte
//  s_keep     in   16   byte enables; contiguous from lane 0
//  s_last     in   1    final beat of the current phase (AAD or payload)
//  s_is_aad   in   1    1 = beat belongs to AAD phase, 0 = payload phase
//  s_ready    out  1    feeder accepts beat
//  aad_valid/aad_data[127:0]/aad_keep[15:0] out, aad_ready in   padded AAD block channel
//  pld_valid/pld_data[127:0]/pld_keep[15:0] out, pld_ready in   padded payload block channel
//  len_valid  out  1; len_block out 128; len_ready in 1          length block channel
//  aad_bytes  out  CNT_W  running AAD byte count
//  pld_bytes  out  CNT_W  running payload byte count
//  busy       out  1    high from start acceptance until len block accepted
//  done       out  1    1-cycle pulse when len block handshake completes
//  err        out  1    sticky protocol error; cleared by start
// BEHAVIOUR
//  Reset: state=IDLE. All *_valid, busy, done, err = 0. All data/keep/len_block/counters = 0. s_ready = 0.
//  FSM: IDLE -start-> AAD -(AAD s_last accepted)-> PLD -(PLD s_last accepted)-> LEN -(len handshake)-> IDLE.
//   - start while not IDLE is ignored. Counters and err are cleared on start acceptance.
//  One output register per channel; a beat accepted at edge N produces *_valid=1 after edge N (1-cycle latency).
//  s_ready = (state AAD & (!aad_valid | aad_ready)) | (state PLD & (!pld_valid | pld_ready)); 0 in IDLE/LEN.
//  Padding: output byte lane i = s_data lane i if s_keep[i], else 8'h00. Output keep is always 16'hFFFF.
//  Count: counter += popcount(s_keep) per accepted beat. Counters wrap mod 2^CNT_W; no saturation.
//  Empty message: an s_last beat with s_keep=0 emits no block and only advances the phase,
//   so zero-length AAD or payload produces no blocks on that channel.
//  Output valid holds with stable data until ready. Simultaneous valid&ready and new-beat acceptance
//   reloads the register in the same cycle with no bubble.
//  LEN state is entered only after the last pld block handshake completes. len_valid=1 the cycle after,
//   with len_block[63:0]=aad_bytes and len_block[127:64]=pld_bytes.
//   len_valid&len_ready -> done pulse, busy=0, state=IDLE; counters keep their values until next start.
//  rst_n asserted mid-message: immediate return to reset values; in-flight block discarded, no done.
// CONFIGURATION
//  FEEDER_CHECK_EN defined: err is set and the offending beat is consumed but dropped (no count,
//   no block) when any of these occur:
//   - non-contiguous s_keep;
//   - s_keep != 16'hFFFF on a non-last beat;
//   - s_is_aad mismatching the current phase.
//   Otherwise the phase/state is unchanged, except a dropped s_last beat still advances the phase.
//  Not defined: err tied 0 and no checks; s_is_aad is ignored (phase is positional); popcount still used.
// TESTING
//  1. start; AAD 12B (keep=0x0FFF, last); payload 32B (2 full beats, last) -> aad block bytes 12..15=00,
//     2 pld blocks, len_block=128'h0000000000000020_000000000000000C, done pulse.
//  2. AAD last beat keep=0 (empty); payload 1B data 0xAB -> no aad_valid ever; pld_data=128'hAB;
//     len_block[63:0]=0, [127:64]=1.
//  3. Hold aad_ready=0 for 5 cycles with AAD block pending -> aad_data stable, s_ready=0;
//     release -> next beat accepted the same cycle.
//  4. Back-to-back full payload beats with pld_ready=1 continuous -> one block per cycle; 4 beats -> pld_bytes=64.
//  5. FEEDER_CHECK_EN: non-last AAD beat keep=16'h00FF -> err=1, no block, aad_bytes unchanged;
//     next start clears err.
//  6. Deassert rst_n while pld_valid=1 -> all outputs 0 async; after release no done; fresh message correct.

Source files
------------

// File: rtl/poly1305_block_feeder_if.sv
// Stream and block-channel bundle for poly1305_block_feeder.
// The master modport is the feeder; the slave modport is the surrounding environment.
interface poly1305_block_feeder_if;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_data;
    logic [15:0]  s_keep;
    logic         s_last;
    logic         s_is_aad;

    logic         aad_valid;
    logic         aad_ready;
    logic [127:0] aad_data;
    logic [15:0]  aad_keep;

    logic         pld_valid;
    logic         pld_ready;
    logic [127:0] pld_data;
    logic [15:0]  pld_keep;

    logic         len_valid;
    logic         len_ready;
    logic [127:0] len_block;

    modport master (
        input  s_valid, s_data, s_keep, s_last, s_is_aad,
        input  aad_ready, pld_ready, len_ready,
        output s_ready,
        output aad_valid, aad_data, aad_keep,
        output pld_valid, pld_data, pld_keep,
        output len_valid, len_block
    );

    modport slave (
        output s_valid, s_data, s_keep, s_last, s_is_aad,
        output aad_ready, pld_ready, len_ready,
        input  s_ready,
        input  aad_valid, aad_data, aad_keep,
        input  pld_valid, pld_data, pld_keep,
        input  len_valid, len_block
    );
endinterface

// File: rtl/poly1305_block_feeder.sv
// Pads AAD/payload byte streams to 16-byte Poly1305 blocks and emits the final length block.
// Defining FEEDER_CHECK_EN enables beat protocol checks with a sticky err flag.
module poly1305_block_feeder #(
    parameter int CNT_W = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    poly1305_block_feeder_if.master bus,
    output logic [CNT_W-1:0]        aad_bytes,
    output logic [CNT_W-1:0]        pld_bytes,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    typedef enum logic [2:0] {IDLE, AAD, PLD, DRAIN, LEN} state_t;

    state_t       state;
    state_t       state_next;
    logic         accept;
    logic         beat_ok;
    logic         in_aad;
    logic         in_pld;
    logic         has_bytes;
    logic         load_aad;
    logic         load_pld;
    logic         pld_empties;
    logic         len_fire;
    logic         enter_len;
    logic [127:0] padded;
    logic [4:0]   beat_bytes;

    always_comb begin
        padded     = '0;
        beat_bytes = '0;
        for (int i = 0; i < 16; i++) begin
            if (bus.s_keep[i]) begin
                padded[8*i +: 8] = bus.s_data[8*i +: 8];
                beat_bytes       = beat_bytes + 5'd1;
            end
        end
    end

    assign in_aad      = (state == AAD);
    assign in_pld      = (state == PLD);
    assign accept      = bus.s_valid & bus.s_ready;
    assign has_bytes   = |bus.s_keep;
    assign load_aad    = accept & in_aad & beat_ok & has_bytes;
    assign load_pld    = accept & in_pld & beat_ok & has_bytes;
    assign pld_empties = !load_pld & (!bus.pld_valid | bus.pld_ready);
    assign len_fire    = bus.len_valid & bus.len_ready;
    assign enter_len   = (state_next == LEN) & (state != LEN);

`ifdef FEEDER_CHECK_EN
    logic keep_contig;
    logic beat_bad;

    // A contiguous-from-lane-0 mask is 2^k-1, so it shares no bits with itself plus one.
    assign keep_contig = (bus.s_keep & (bus.s_keep + 16'd1)) == 16'd0;
    assign beat_bad    = !keep_contig
                       | (!bus.s_last & (bus.s_keep != 16'hFFFF))
                       | (bus.s_is_aad != in_aad);
    assign beat_ok     = !beat_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     err <= 1'b0;
        else if (state == IDLE && start) err <= 1'b0;
        else if (accept & beat_bad)      err <= 1'b1;
    end
`else
    logic unused_is_aad;
    assign unused_is_aad = bus.s_is_aad;
    assign beat_ok       = 1'b1;
    assign err           = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // DRAIN holds off the length block until the final payload block has been taken.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = AAD;
            AAD:     if (accept & bus.s_last) state_next = PLD;
            PLD:     if (accept & bus.s_last) state_next = pld_empties ? LEN : DRAIN;
            DRAIN:   if (!bus.pld_valid | bus.pld_ready) state_next = LEN;
            LEN:     if (len_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.s_ready = 1'b0;
        unique case (state)
            AAD:     bus.s_ready = !bus.aad_valid | bus.aad_ready;
            PLD:     bus.s_ready = !bus.pld_valid | bus.pld_ready;
            default: bus.s_ready = 1'b0;
        endcase
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.aad_valid <= 1'b0;
            bus.aad_data  <= '0;
            bus.aad_keep  <= '0;
            bus.pld_valid <= 1'b0;
            bus.pld_data  <= '0;
            bus.pld_keep  <= '0;
            bus.len_valid <= 1'b0;
            bus.len_block <= '0;
            aad_bytes     <= '0;
            pld_bytes     <= '0;
            done          <= 1'b0;
        end else begin
            done <= len_fire;

            if (state == IDLE && start) begin
                aad_bytes <= '0;
                pld_bytes <= '0;
            end else if (accept & beat_ok & in_aad) begin
                aad_bytes <= aad_bytes + CNT_W'(beat_bytes);
            end else if (accept & beat_ok & in_pld) begin
                pld_bytes <= pld_bytes + CNT_W'(beat_bytes);
            end

            if (load_aad) begin
                bus.aad_valid <= 1'b1;
                bus.aad_data  <= padded;
                bus.aad_keep  <= 16'hFFFF;
            end else if (bus.aad_ready) begin
                bus.aad_valid <= 1'b0;
            end

            if (load_pld) begin
                bus.pld_valid <= 1'b1;
                bus.pld_data  <= padded;
                bus.pld_keep  <= 16'hFFFF;
            end else if (bus.pld_ready) begin
                bus.pld_valid <= 1'b0;
            end

            if (enter_len) begin
                bus.len_valid <= 1'b1;
                bus.len_block <= {64'(pld_bytes), 64'(aad_bytes)};
            end else if (bus.len_ready) begin
                bus.len_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_poly1305_block_feeder.sv
// Directed self-checking bench for poly1305_block_feeder (FEEDER_CHECK_EN-aware).
module tb_poly1305_block_feeder;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] aad_bytes;
    logic [63:0] pld_bytes;
    logic        busy;
    logic        done;
    logic        err;
    int          checks;
    int          failures;
    int          waited;

    poly1305_block_feeder_if bus ();

    poly1305_block_feeder #(.CNT_W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus),
        .aad_bytes (aad_bytes),
        .pld_bytes (pld_bytes),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offers one beat and returns once it has been accepted (bounded wait).
    task automatic apply_stimulus(input logic [127:0] data, input logic [15:0] keep, input logic last,
                                  input logic is_aad, output int cycles);
        bus.s_valid  = 1'b1;
        bus.s_data   = data;
        bus.s_keep   = keep;
        bus.s_last   = last;
        bus.s_is_aad = is_aad;
        cycles = 0;
        while (!bus.s_ready && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        check_output("s_ready_before_accept", 128'(bus.s_ready), 128'd1);
        if (bus.s_ready) begin
            @(posedge clk); #1;
            cycles++;
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_output("busy_after_start", 128'(busy), 128'd1);
    endtask

    task automatic expect_len(input logic [127:0] exp_block);
        for (int i = 0; i < 10 && !bus.len_valid; i++) begin
            @(posedge clk); #1;
        end
        check_output("len_valid", 128'(bus.len_valid), 128'd1);
        check_output("len_block", bus.len_block, exp_block);
        bus.len_ready = 1'b1;
        @(posedge clk); #1;
        bus.len_ready = 1'b0;
        check_output("done_pulse", 128'(done), 128'd1);
        check_output("busy_after_len", 128'(busy), 128'd0);
        @(posedge clk); #1;
        check_output("done_single", 128'(done), 128'd0);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        start         = 1'b0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.s_keep    = '0;
        bus.s_last    = 1'b0;
        bus.s_is_aad  = 1'b0;
        bus.aad_ready = 1'b1;
        bus.pld_ready = 1'b1;
        bus.len_ready = 1'b0;

        #12;
        check_output("rst_busy", 128'(busy), 128'd0);
        check_output("rst_s_ready", 128'(bus.s_ready), 128'd0);
        check_output("rst_aad_valid", 128'(bus.aad_valid), 128'd0);
        check_output("rst_len_block", bus.len_block, 128'd0);
        check_output("rst_err", 128'(err), 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("[TB] case 1: 12B AAD, 32B payload");
        do_start();
        apply_stimulus(128'hFFEEDDCC_BBAA9988_77665544_33221100, 16'h0FFF, 1'b1, 1'b1, waited);
        check_output("t1_aad_valid", 128'(bus.aad_valid), 128'd1);
        check_output("t1_aad_data", bus.aad_data, 128'h00000000_BBAA9988_77665544_33221100);
        check_output("t1_aad_keep", 128'(bus.aad_keep), 128'hFFFF);
        check_output("t1_aad_bytes", 128'(aad_bytes), 128'd12);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_output("t1_start_ignored", 128'(aad_bytes), 128'd12);
        apply_stimulus(128'h01234567_89ABCDEF_FEDCBA98_76543210, 16'hFFFF, 1'b0, 1'b0, waited);
        check_output("t1_pld_data0", bus.pld_data, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
        apply_stimulus(128'hDEADBEEF_CAFEF00D_0BADC0DE_12345678, 16'hFFFF, 1'b1, 1'b0, waited);
        check_output("t1_pld_data1", bus.pld_data, 128'hDEADBEEF_CAFEF00D_0BADC0DE_12345678);
        check_output("t1_pld_bytes", 128'(pld_bytes), 128'd32);
        check_output("t1_len_not_yet", 128'(bus.len_valid), 128'd0);
        @(posedge clk); #1;
        check_output("t1_len_after_drain", 128'(bus.len_valid), 128'd1);
        expect_len(128'h0000000000000020_000000000000000C);

        $display("[TB] case 2: empty AAD, 1B payload");
        do_start();
        apply_stimulus(128'hFFFF_FFFF, 16'h0000, 1'b1, 1'b1, waited);
        check_output("t2_no_aad", 128'(bus.aad_valid), 128'd0);
        apply_stimulus(128'h11111111_11111111_11111111_111111AB, 16'h0001, 1'b1, 1'b0, waited);
        check_output("t2_pld_data", bus.pld_data, 128'h000000AB);
        check_output("t2_pld_bytes", 128'(pld_bytes), 128'd1);
        check_output("t2_still_no_aad", 128'(bus.aad_valid), 128'd0);
        expect_len(128'h0000000000000001_0000000000000000);

        $display("[TB] case 3: AAD backpressure");
        do_start();
        bus.aad_ready = 1'b0;
        apply_stimulus(128'hA1A1A1A1_A1A1A1A1_A1A1A1A1_A1A1A1A1, 16'hFFFF, 1'b0, 1'b1, waited);
        bus.s_valid  = 1'b1;
        bus.s_data   = 128'hA2A2A2A2_A2A2A2A2_A2A2A2A2_A2A2A2A2;
        bus.s_keep   = 16'hFFFF;
        bus.s_last   = 1'b1;
        bus.s_is_aad = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_output("t3_s_ready_held", 128'(bus.s_ready), 128'd0);
            check_output("t3_aad_data_stable", bus.aad_data, 128'hA1A1A1A1_A1A1A1A1_A1A1A1A1_A1A1A1A1);
            @(posedge clk); #1;
        end
        bus.aad_ready = 1'b1;
        #1;
        check_output("t3_s_ready_release", 128'(bus.s_ready), 128'd1);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        check_output("t3_reload_valid", 128'(bus.aad_valid), 128'd1);
        check_output("t3_reload_data", bus.aad_data, 128'hA2A2A2A2_A2A2A2A2_A2A2A2A2_A2A2A2A2);
        check_output("t3_aad_bytes", 128'(aad_bytes), 128'd32);
        apply_stimulus(128'd0, 16'h0000, 1'b1, 1'b0, waited);
        expect_len(128'h0000000000000000_0000000000000020);

        $display("[TB] case 4: back-to-back payload");
        do_start();
        apply_stimulus(128'd0, 16'h0000, 1'b1, 1'b1, waited);
        for (int k = 0; k < 4; k++) begin
            apply_stimulus({4{32'hA5A50000 + 32'(k)}}, 16'hFFFF, k == 3, 1'b0, waited);
            check_output("t4_one_cycle", 128'(waited), 128'd1);
            check_output("t4_pld_valid", 128'(bus.pld_valid), 128'd1);
            check_output("t4_pld_data", bus.pld_data, {4{32'hA5A50000 + 32'(k)}});
            check_output("t4_pld_bytes", 128'(pld_bytes), 128'(16 * (k + 1)));
        end
        expect_len(128'h0000000000000040_0000000000000000);

        $display("[TB] case 5: partial non-last AAD beat");
        do_start();
        apply_stimulus(128'hFFEEDDCC_BBAA9988_77665544_33221100, 16'h00FF, 1'b0, 1'b1, waited);
`ifdef FEEDER_CHECK_EN
        check_output("t5_err_set", 128'(err), 128'd1);
        check_output("t5_no_block", 128'(bus.aad_valid), 128'd0);
        check_output("t5_aad_bytes", 128'(aad_bytes), 128'd0);
        apply_stimulus(128'd0, 16'h0000, 1'b1, 1'b1, waited);
        apply_stimulus(128'd0, 16'h0000, 1'b1, 1'b0, waited);
        expect_len(128'h0000000000000000_0000000000000000);
        check_output("t5_err_sticky", 128'(err), 128'd1);
        do_start();
        check_output("t5_err_cleared", 128'(err), 128'd0);
`else
        check_output("t5_err_tied", 128'(err), 128'd0);
        check_output("t5_block", 128'(bus.aad_valid), 128'd1);
        check_output("t5_data", bus.aad_data, 128'h00000000_00000000_77665544_33221100);
        check_output("t5_aad_bytes", 128'(aad_bytes), 128'd8);
        apply_stimulus(128'd0, 16'h0000, 1'b1, 1'b1, waited);
        apply_stimulus(128'd0, 16'h0000, 1'b1, 1'b0, waited);
        expect_len(128'h0000000000000000_0000000000000008);
        do_start();
        check_output("t5_cnt_cleared", 128'(aad_bytes), 128'd0);
`endif
        apply_stimulus(128'd0, 16'h0000, 1'b1, 1'b1, waited);
        apply_stimulus(128'd0, 16'h0000, 1'b1, 1'b0, waited);
        expect_len(128'h0000000000000000_0000000000000000);

        $display("[TB] case 6: reset mid-message");
        do_start();
        apply_stimulus(128'd0, 16'h0000, 1'b1, 1'b1, waited);
        bus.pld_ready = 1'b0;
        apply_stimulus(128'h55555555_55555555_55555555_55555555, 16'hFFFF, 1'b1, 1'b0, waited);
        check_output("t6_pld_pending", 128'(bus.pld_valid), 128'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_output("t6_async_pld_valid", 128'(bus.pld_valid), 128'd0);
        check_output("t6_async_pld_data", bus.pld_data, 128'd0);
        check_output("t6_async_busy", 128'(busy), 128'd0);
        check_output("t6_async_pld_bytes", 128'(pld_bytes), 128'd0);
        check_output("t6_async_s_ready", 128'(bus.s_ready), 128'd0);
        @(posedge clk); #1;
        rst_n         = 1'b1;
        bus.pld_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_output("t6_no_done", 128'(done), 128'd0);
            check_output("t6_no_len", 128'(bus.len_valid), 128'd0);
        end
        do_start();
        apply_stimulus(128'h0F0E0D0C_0B0A0908_07060504_03020100, 16'hFFFF, 1'b1, 1'b1, waited);
        check_output("t6_fresh_aad", bus.aad_data, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        apply_stimulus(128'd0, 16'h0000, 1'b1, 1'b0, waited);
        expect_len(128'h0000000000000000_0000000000000010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
